jtgng_main_ctrl: RTL and testbench

JTGNG_MAIN_CTRL -- requirements
Module: jtgng_main_ctrl

---
 rtl/jtgng_main_ctrl.sv | 178 +++++++++++++++++
 tb/tb_jtgng_main_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/jtgng_main_ctrl.sv
// Main CPU glue for the 6809 board: bank/misc registers, CPU reset
// sequencing, vblank IRQ, sound-latch FIFO and ROM stall/timeout gating.
module jtgng_main_ctrl #(
    parameter int BANKW   = 3,
    parameter int SNDQ    = 4,
    parameter int COINS   = 2,
    parameter int COINW   = 4,
    parameter int RSTCYC  = 16,
    parameter int WAITMAX = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cen,
    input  logic                   soft_rst,
    input  logic [15:0]            cpu_addr,
    input  logic [7:0]             cpu_dout,
    input  logic                   cpu_rnw,
    input  logic                   cpu_bs,
    input  logic                   cpu_ba,
    input  logic                   bank_cs,
    input  logic                   misc_cs,
    input  logic                   snd_cs,
    input  logic                   rom_cs,
    input  logic                   rom_ok,
    input  logic                   lvbl,
    input  logic                   snd_rd,
    output logic                   cpu_cen,
    output logic                   cpu_nreset,
    output logic                   cpu_nirq,
    output logic [BANKW-1:0]       bank,
    output logic                   flip,
    output logic                   sres_b,
    output logic [7:0]             snd_latch,
    output logic                   snd_pending,
    output logic                   snd_ovf,
    output logic [COINS*COINW-1:0] coin_cnt,
    output logic                   rom_tout
);

    localparam int QW = $clog2(SNDQ);
    localparam int RW = $clog2(RSTCYC + 1);
    localparam int WW = $clog2(WAITMAX + 1);

    logic [BANKW-1:0]       bank_q, bank_d;
    logic                   flip_q, flip_d, sres_q, sres_d;
    logic [COINS*COINW-1:0] coin_q, coin_d;
    logic [RW-1:0]          rcnt_q, rcnt_d;
    logic                   lvbl_q, lvbl_d, nirq_q, nirq_d;
    logic [7:0]             mem [SNDQ];
    logic [QW-1:0]          wp_q, wp_d, rp_q, rp_d;
    logic [QW:0]            cnt_q, cnt_d;
    logic [7:0]             last_q, last_d;
    logic                   ovf_q, ovf_d;
    logic [WW-1:0]          scnt_q, scnt_d;
    logic                   rel_q, rel_d, tout_q, tout_d;

    logic wr_en, push, full, empty, do_push, do_pop;
    logic counting, reach, stall, fall, ack;

    // Only the low three address bits select a misc register.
    logic unused_addr;
    assign unused_addr = &{1'b0, cpu_addr[15:3]};

    // A stalled ROM fetch holds the CPU unless the timeout has released it.
    assign counting = rom_cs & ~rom_ok;
    assign stall    = counting & ~rel_q;
    assign cpu_cen  = cen & ~stall;
    assign wr_en    = cpu_cen & ~cpu_rnw;

    assign push     = wr_en & snd_cs;
    assign full     = (cnt_q == (QW+1)'(SNDQ));
    assign empty    = (cnt_q == '0);
    assign do_pop   = snd_rd & ~empty;
    assign do_push  = push & (~full | do_pop);

    assign fall     = cen & lvbl_q & ~lvbl;
    assign ack      = cen & cpu_bs & ~cpu_ba;
    assign reach    = counting & (scnt_q == WW'(WAITMAX - 1));

    // Next-state for registers, CPU reset count, IRQ, FIFO control and stall timer.
    always_comb begin
        bank_d = bank_q;
        flip_d = flip_q;
        sres_d = sres_q;
        coin_d = coin_q;
        if (wr_en & bank_cs) bank_d = cpu_dout[BANKW-1:0];
        if (wr_en & misc_cs) begin
            case (cpu_addr[2:0])
                3'd0:    flip_d = cpu_dout[0];
                3'd1:    sres_d = cpu_dout[0];
                default: ;
            endcase
            for (int k = 0; k < COINS; k++) begin
                if (cpu_addr[2:0] == 3'(k + 2))
                    coin_d[k*COINW +: COINW] = coin_q[k*COINW +: COINW] + COINW'(cpu_dout[0]);
            end
        end

        rcnt_d = rcnt_q;
        if (soft_rst)                  rcnt_d = RW'(RSTCYC);
        else if (cen && rcnt_q != '0)  rcnt_d = rcnt_q - 1'b1;

        lvbl_d = cen ? lvbl : lvbl_q;
        nirq_d = nirq_q;
        if (fall)     nirq_d = 1'b0;
        else if (ack) nirq_d = 1'b1;

        wp_d   = wp_q + QW'(do_push);
        rp_d   = rp_q + QW'(do_pop);
        cnt_d  = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: ;
        endcase
        last_d = do_pop ? mem[rp_q] : last_q;
        ovf_d  = ovf_q | (push & full & ~snd_rd);

        scnt_d = '0;
        if (counting) scnt_d = (scnt_q == WW'(WAITMAX)) ? scnt_q : scnt_q + 1'b1;
        rel_d  = rom_cs & (rel_q | reach);
        tout_d = tout_q | reach;
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q <= '0;
            flip_q <= 1'b0;
            sres_q <= 1'b1;
            coin_q <= '0;
            rcnt_q <= RW'(RSTCYC);
            lvbl_q <= 1'b0;
            nirq_q <= 1'b1;
            wp_q   <= '0;
            rp_q   <= '0;
            cnt_q  <= '0;
            last_q <= '0;
            ovf_q  <= 1'b0;
            scnt_q <= '0;
            rel_q  <= 1'b0;
            tout_q <= 1'b0;
        end else begin
            bank_q <= bank_d;
            flip_q <= flip_d;
            sres_q <= sres_d;
            coin_q <= coin_d;
            rcnt_q <= rcnt_d;
            lvbl_q <= lvbl_d;
            nirq_q <= nirq_d;
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            cnt_q  <= cnt_d;
            last_q <= last_d;
            ovf_q  <= ovf_d;
            scnt_q <= scnt_d;
            rel_q  <= rel_d;
            tout_q <= tout_d;
        end
    end

    // FIFO storage; a full push+pop overwrites the slot being popped, which becomes the tail.
    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[wp_q] <= cpu_dout;
    end

    assign cpu_nreset  = ~rst & ~soft_rst & (rcnt_q == '0);
    assign cpu_nirq    = nirq_q;
    assign bank        = bank_q;
    assign flip        = flip_q;
    assign sres_b      = sres_q;
    assign coin_cnt    = coin_q;
    assign snd_latch   = empty ? last_q : mem[rp_q];
    assign snd_pending = ~empty;
    assign snd_ovf     = ovf_q;
    assign rom_tout    = tout_q;

endmodule

// File: tb/tb_jtgng_main_ctrl.sv
// Directed bench for jtgng_main_ctrl.
module tb_jtgng_main_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, cen, soft_rst, cpu_rnw, cpu_bs, cpu_ba;
    logic        bank_cs, misc_cs, snd_cs, rom_cs, rom_ok, lvbl, snd_rd;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_cen, cpu_nreset, cpu_nirq, flip, sres_b;
    logic        snd_pending, snd_ovf, rom_tout;
    logic [2:0]  bank;
    logic [7:0]  snd_latch;
    logic [7:0]  coin_cnt;

    int checks = 0;
    int errors = 0;
    int zeros, first;

    jtgng_main_ctrl #(
        .BANKW(3), .SNDQ(4), .COINS(2), .COINW(4), .RSTCYC(16), .WAITMAX(255)
    ) dut (
        .clk(clk), .rst(rst), .cen(cen), .soft_rst(soft_rst),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_rnw(cpu_rnw),
        .cpu_bs(cpu_bs), .cpu_ba(cpu_ba), .bank_cs(bank_cs), .misc_cs(misc_cs),
        .snd_cs(snd_cs), .rom_cs(rom_cs), .rom_ok(rom_ok), .lvbl(lvbl),
        .snd_rd(snd_rd), .cpu_cen(cpu_cen), .cpu_nreset(cpu_nreset),
        .cpu_nirq(cpu_nirq), .bank(bank), .flip(flip), .sres_b(sres_b),
        .snd_latch(snd_latch), .snd_pending(snd_pending), .snd_ovf(snd_ovf),
        .coin_cnt(coin_cnt), .rom_tout(rom_tout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cen_pulse();
        cen = 1'b1; step();
        cen = 1'b0; step(); step(); step();
    endtask

    // sel: 0 bank, 1 misc, 2 sound latch
    task automatic wr(input int sel, input logic [2:0] a, input logic [7:0] d, input logic rd);
        cpu_addr = {13'd0, a};
        cpu_dout = d;
        cpu_rnw  = 1'b0;
        bank_cs  = (sel == 0);
        misc_cs  = (sel == 1);
        snd_cs   = (sel == 2);
        snd_rd   = rd;
        cen      = 1'b1;
        step();
        cen = 1'b0; cpu_rnw = 1'b1; bank_cs = 0; misc_cs = 0; snd_cs = 0; snd_rd = 0;
        step(); step(); step();
    endtask

    task automatic pop();
        snd_rd = 1'b1; step();
        snd_rd = 1'b0; step();
    endtask

    initial begin
        rst = 1; cen = 0; soft_rst = 0; cpu_rnw = 1; cpu_bs = 0; cpu_ba = 0;
        bank_cs = 0; misc_cs = 0; snd_cs = 0; rom_cs = 0; rom_ok = 0;
        lvbl = 1; snd_rd = 0; cpu_addr = '0; cpu_dout = '0;
        step(); step(); step();

        chk("rst_bank", bank, 0);
        chk("rst_flip", flip, 0);
        chk("rst_sres", sres_b, 1);
        chk("rst_coin", coin_cnt, 0);
        chk("rst_nirq", cpu_nirq, 1);
        chk("rst_nreset", cpu_nreset, 0);
        chk("rst_pending", snd_pending, 0);
        chk("rst_latch", snd_latch, 0);
        chk("rst_ovf", snd_ovf, 0);
        chk("rst_tout", rom_tout, 0);

        // CPU reset release after 16 cen pulses
        rst = 0; step();
        repeat (15) cen_pulse();
        chk("nreset_15", cpu_nreset, 0);
        cen_pulse();
        chk("nreset_16", cpu_nreset, 1);

        // soft reset restarts the count mid-sequence
        soft_rst = 1; step();
        chk("soft_hold", cpu_nreset, 0);
        soft_rst = 0; step();
        repeat (9) cen_pulse();
        soft_rst = 1; cen = 1; step();
        soft_rst = 0; cen = 0; step(); step(); step();
        repeat (15) cen_pulse();
        chk("soft_restart_15", cpu_nreset, 0);
        cen_pulse();
        chk("soft_restart_16", cpu_nreset, 1);

        // bank register
        wr(0, 3'd0, 8'h05, 1'b0);
        chk("bank_5", bank, 5);
        wr(0, 3'd0, 8'hFA, 1'b0);
        chk("bank_trunc", bank, 2);
        cpu_rnw = 1; bank_cs = 1; cpu_dout = 8'h07; cen_pulse(); bank_cs = 0;
        chk("bank_read_noeffect", bank, 2);

        // misc page
        wr(1, 3'd0, 8'h01, 1'b0);
        chk("flip_set", flip, 1);
        wr(1, 3'd1, 8'h00, 1'b0);
        chk("sres_clr", sres_b, 0);
        wr(1, 3'd2, 8'h01, 1'b0);
        wr(1, 3'd2, 8'h01, 1'b0);
        wr(1, 3'd3, 8'h01, 1'b0);
        chk("coin_223", coin_cnt, 8'h12);
        wr(1, 3'd4, 8'h01, 1'b0);
        wr(1, 3'd2, 8'h00, 1'b0);
        chk("coin_ignored", coin_cnt, 8'h12);
        repeat (16) wr(1, 3'd2, 8'h01, 1'b0);
        chk("coin_wrap", coin_cnt, 8'h12);

        // vblank IRQ
        chk("nirq_idle", cpu_nirq, 1);
        lvbl = 0; cen_pulse();
        chk("nirq_fall", cpu_nirq, 0);
        cpu_bs = 1; cpu_ba = 0; cen_pulse(); cpu_bs = 0;
        chk("nirq_ack", cpu_nirq, 1);
        lvbl = 1; cen_pulse();
        chk("nirq_rise_nochg", cpu_nirq, 1);
        lvbl = 0; cpu_bs = 1; cpu_ba = 0; cen_pulse(); cpu_bs = 0;
        chk("nirq_ack_vs_fall", cpu_nirq, 0);
        lvbl = 1;

        // FIFO overflow and draining
        wr(2, 3'd0, 8'h11, 1'b0);
        chk("fifo_first", snd_latch, 8'h11);
        chk("fifo_pend", snd_pending, 1);
        wr(2, 3'd0, 8'h22, 1'b0);
        wr(2, 3'd0, 8'h33, 1'b0);
        wr(2, 3'd0, 8'h44, 1'b0);
        chk("fifo_full_noovf", snd_ovf, 0);
        wr(2, 3'd0, 8'h55, 1'b0);
        chk("fifo_ovf", snd_ovf, 1);
        chk("fifo_head_kept", snd_latch, 8'h11);
        pop(); chk("pop1", snd_latch, 8'h22);
        pop(); chk("pop2", snd_latch, 8'h33);
        pop(); chk("pop3", snd_latch, 8'h44);
        chk("pop3_pend", snd_pending, 1);
        pop(); chk("pop4_pend", snd_pending, 0);
        chk("pop4_latch", snd_latch, 8'h44);
        pop(); chk("empty_pop_latch", snd_latch, 8'h44);
        chk("empty_pop_pend", snd_pending, 0);
        wr(2, 3'd0, 8'h77, 1'b1);
        chk("empty_pushpop_pend", snd_pending, 1);
        chk("empty_pushpop_latch", snd_latch, 8'h77);
        pop(); chk("drain77", snd_pending, 0);

        // reset mid-operation
        rst = 1; step(); rst = 0; step();
        chk("rst2_ovf", snd_ovf, 0);
        chk("rst2_latch", snd_latch, 0);
        chk("rst2_bank", bank, 0);
        chk("rst2_coin", coin_cnt, 0);
        chk("rst2_sres", sres_b, 1);

        // full push+pop
        wr(2, 3'd0, 8'h11, 1'b0);
        wr(2, 3'd0, 8'h22, 1'b0);
        wr(2, 3'd0, 8'h33, 1'b0);
        wr(2, 3'd0, 8'h44, 1'b0);
        wr(2, 3'd0, 8'h66, 1'b1);
        chk("full_pp_ovf", snd_ovf, 0);
        chk("full_pp_head", snd_latch, 8'h22);
        pop(); chk("fpp_pop1", snd_latch, 8'h33);
        pop(); chk("fpp_pop2", snd_latch, 8'h44);
        pop(); chk("fpp_pop3", snd_latch, 8'h66);
        chk("fpp_pend3", snd_pending, 1);
        pop(); chk("fpp_pend4", snd_pending, 0);

        // ROM stall and timeout
        cen = 1; rom_cs = 1; rom_ok = 0; zeros = 0; first = -1;
        for (int i = 0; i < 300; i++) begin
            if (cpu_cen === 1'b0) zeros++;
            else if (first < 0) first = i;
            step();
        end
        chk("stall_len", zeros, 255);
        chk("stall_release_at", first, 255);
        chk("stall_released", cpu_cen, 1);
        chk("tout_set", rom_tout, 1);
        rom_cs = 0; step();
        chk("tout_sticky", rom_tout, 1);
        rst = 1; step(); rst = 0; step();
        chk("tout_rst", rom_tout, 0);

        rom_cs = 1; rom_ok = 0;
        repeat (254) step();
        chk("edge_stalled", cpu_cen, 0);
        rom_ok = 1; step();
        chk("edge_no_tout", rom_tout, 0);
        chk("edge_cen", cpu_cen, 1);
        rom_ok = 0; #1;
        chk("edge_restall", cpu_cen, 0);
        rom_cs = 0; step();

        rom_cs = 1; rom_ok = 0;
        repeat (100) step();
        rom_ok = 1;
        repeat (200) step();
        chk("ok100_no_tout", rom_tout, 0);
        rom_cs = 0; rom_ok = 0; cen = 0; step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
